lfsr_rng: RTL and testbench

LFSR_RNG -- requirements
Module: lfsr_rng

---
 rtl/rng_pkg.sv | 19 +
 rtl/lfsr_rng_if.sv | 26 ++
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_rng.sv | 117 +++++++++++
 tb/tb_lfsr_rng.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the ranged LFSR random generator.
// Holds the draw FSM encoding and maximal-length Fibonacci tap masks.
package rng_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } rng_state_e;

    // Feedback masks (bit i set -> lfsr[i] feeds the XOR) for common widths.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    // Width of the rejection counter; covers MAX_TRIES up to 255.
    localparam int TRIES_W = 8;

endpackage

// File: rtl/lfsr_rng_if.sv
// Signal bundle between a requester and the ranged LFSR generator.
// The master drives seeding/requests; the slave returns status and results.
interface lfsr_rng_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 2
);
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             free_run;
    logic             req;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic             fallback;
    logic [WIDTH-1:0] raw;

    modport master (
        output seed_load, seed, free_run, req,
        input  busy, valid, value, fallback, raw
    );

    modport slave (
        input  seed_load, seed, free_run, req,
        output busy, valid, value, fallback, raw
    );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and a guard that keeps it out of
// the all-zero lock-up state.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            // A zero seed would freeze the sequence, so substitute all-ones.
            lfsr_d = (seed_i == '0) ? '1 : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= '1;
        else       lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/lfsr_rng.sv
// Ranged random generator: rejection-samples the low LFSR bits into
// [0, RANGE), falling back to a folded candidate after MAX_TRIES rejections.
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_W16),
    parameter int               RANGE     = 3,
    parameter int               MAX_TRIES = 8,
    localparam int              OUT_W     = $clog2(RANGE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             free_run,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic             fallback,
    output logic [WIDTH-1:0] raw
);

    localparam logic [OUT_W:0]     RANGE_V  = (OUT_W + 1)'(RANGE);
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    rng_state_e         state_q, state_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0]   value_q, value_d;
    logic               valid_q, valid_d;
    logic               fallback_q, fallback_d;
    logic               lfsr_step;
    logic [WIDTH-1:0]   lfsr_state;
    logic [OUT_W-1:0]   cand;
    logic [OUT_W:0]     folded;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .load_i  (seed_load),
        .seed_i  (seed),
        .step_i  (lfsr_step),
        .state_o (lfsr_state)
    );

    assign cand = lfsr_state[OUT_W-1:0];
    // 2^OUT_W < 2*RANGE, so a rejected candidate minus RANGE is in range.
    assign folded = {1'b0, cand} - RANGE_V;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        fallback_d = 1'b0;
        lfsr_step  = 1'b0;

        if (seed_load) begin
            state_d = ST_IDLE;
            tries_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    lfsr_step = free_run;
                    if (req) begin
                        state_d = ST_DRAW;
                        tries_d = '0;
                    end
                end
                ST_DRAW: begin
                    lfsr_step = 1'b1;
                    if ({1'b0, cand} < RANGE_V) begin
                        value_d = cand;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        value_d    = folded[OUT_W-1:0];
                        valid_d    = 1'b1;
                        fallback_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tries_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            fallback_q <= fallback_d;
        end
    end

    assign busy     = (state_q == ST_DRAW);
    assign valid    = valid_q;
    assign value    = value_q;
    assign fallback = fallback_q;
    assign raw      = lfsr_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: three instances (RANGE 3/8 tries, RANGE 3/1 try,
// RANGE 4) share stimulus and are scored against a transaction-level model.
module tb_lfsr_rng;

    logic        clk;
    logic        reset;
    logic        sl;
    logic [15:0] sd;
    logic        fr;
    logic        rq;

    logic [15:0] o_raw[3];
    logic        o_busy[3];
    logic        o_valid[3];
    logic [1:0]  o_value[3];
    logic        o_fb[3];

    int n_checks = 0;
    int n_errors = 0;
    bit do_cmp   = 1'b1;
    int fb2_cnt  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int R = (g == 2) ? 4 : 3;
        localparam int M = (g == 1) ? 1 : 8;

        lfsr_rng_if #(.WIDTH(16), .OUT_W(2)) bus ();

        assign bus.seed_load = sl;
        assign bus.seed      = sd;
        assign bus.free_run  = fr;
        assign bus.req       = rq;

        lfsr_rng #(
            .WIDTH     (16),
            .TAPS      (16'hB400),
            .RANGE     (R),
            .MAX_TRIES (M)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .seed_load (bus.seed_load),
            .seed      (bus.seed),
            .free_run  (bus.free_run),
            .req       (bus.req),
            .busy      (bus.busy),
            .valid     (bus.valid),
            .value     (bus.value),
            .fallback  (bus.fallback),
            .raw       (bus.raw)
        );

        assign o_raw[g]   = bus.raw;
        assign o_busy[g]  = bus.busy;
        assign o_valid[g] = bus.valid;
        assign o_value[g] = bus.value;
        assign o_fb[g]    = bus.fallback;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a draw is planned in full when it is accepted.
    typedef struct {
        logic [15:0] lfsr;
        int          left;
        int          pend_v;
        bit          pend_fb;
        bit          valid;
        int          value;
        bit          fb;
    } mdl_t;

    mdl_t m[3];
    int   rng_of[3] = '{3, 3, 4};
    int   mt_of[3]  = '{8, 1, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] s);
        int ones = $countones(s & 16'hB400);
        return 16'((32'(s) * 2 + (ones % 2)) % 65536);
    endfunction

    function automatic void plan_draw(input logic [15:0] s, input int rng, input int mt,
                                      output int res, output bit fb, output int n);
        int modv = 1 << $clog2(rng);
        res = 0;
        fb  = 1'b0;
        n   = 0;
        for (int t = 0; t < mt; t++) begin
            int c = int'(s) % modv;
            n = t + 1;
            s = nxt(s);
            if (c < rng) begin
                res = c;
                return;
            end
            if (t == mt - 1) begin
                res = c - rng;
                fb  = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m[i].lfsr  = 16'hFFFF;
            m[i].left  = 0;
            m[i].valid = 1'b0;
            m[i].value = 0;
            m[i].fb    = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        m[i].valid = 1'b0;
        m[i].fb    = 1'b0;
        if (sl) begin
            m[i].lfsr = (sd == 16'h0) ? 16'hFFFF : sd;
            m[i].left = 0;
        end else if (m[i].left == 0) begin
            if (fr) m[i].lfsr = nxt(m[i].lfsr);
            if (rq) plan_draw(m[i].lfsr, rng_of[i], mt_of[i], m[i].pend_v, m[i].pend_fb, m[i].left);
        end else begin
            m[i].lfsr = nxt(m[i].lfsr);
            m[i].left--;
            if (m[i].left == 0) begin
                m[i].valid = 1'b1;
                m[i].value = m[i].pend_v;
                m[i].fb    = m[i].pend_fb;
            end
        end
    endtask

    task automatic compare(input int i);
        check($sformatf("raw%0d", i),   o_raw[i],   m[i].lfsr);
        check($sformatf("busy%0d", i),  o_busy[i],  32'(m[i].left != 0));
        check($sformatf("valid%0d", i), o_valid[i], 32'(m[i].valid));
        check($sformatf("value%0d", i), o_value[i], m[i].value);
        if (m[i].valid) check($sformatf("fallback%0d", i), o_fb[i], 32'(m[i].fb));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        @(negedge clk);
        if (o_valid[2] && o_fb[2]) fb2_cnt++;
        if (do_cmp) for (int i = 0; i < 3; i++) compare(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            compare(i);
            check($sformatf("rst_fb%0d", i), o_fb[i], 0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic seed_with(input logic [15:0] v);
        sl = 1'b1;
        sd = v;
        tick();
        sl = 1'b0;
    endtask

    initial begin
        int zeros = 0;
        int ret   = 0;
        int cnt[4] = '{0, 0, 0, 0};
        int total  = 0;

        reset = 1'b1;
        sl = 1'b0; sd = 16'h0; fr = 1'b0; rq = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Free-running period of the 16-bit sequence.
        fr = 1'b1;
        do_cmp = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (o_raw[0] == 16'h0) zeros++;
            if (o_raw[0] == 16'hFFFF && ret == 0) ret = i;
        end
        do_cmp = 1'b1;
        check("period_zero_seen", zeros, 0);
        check("period_return", ret, 65535);
        for (int i = 0; i < 3; i++) compare(i);
        fr = 1'b0;

        // Zero seed is replaced by all-ones.
        seed_with(16'h0000);
        check("seed0_raw", o_raw[0], 16'hFFFF);

        // Reject 3, step to 0x0006, accept 2; one-try instance falls back to 0.
        seed_with(16'h0003);
        rq = 1'b1;
        tick();
        rq = 1'b0;
        check("d1_busy", o_busy[0], 1);
        tick();
        check("d1_raw_after_reject", o_raw[0], 16'h0006);
        check("d1_busy_2nd", o_busy[0], 1);
        check("d1_valid_early", o_valid[0], 0);
        check("mt1_valid", o_valid[1], 1);
        check("mt1_value", o_value[1], 0);
        check("mt1_fallback", o_fb[1], 1);
        check("mt1_busy", o_busy[1], 0);
        tick();
        check("d1_valid", o_valid[0], 1);
        check("d1_value", o_value[0], 2);
        check("d1_fallback", o_fb[0], 0);
        check("d1_busy_done", o_busy[0], 0);
        tick();
        check("d1_valid_one_cycle", o_valid[0], 0);
        check("d1_value_held", o_value[0], 2);

        // Seed load aborts a draw in flight.
        seed_with(16'h0003);
        rq = 1'b1;
        tick();
        rq = 1'b0;
        seed_with(16'h1234);
        check("abort_busy", o_busy[0], 0);
        check("abort_valid", o_valid[0], 0);
        check("abort_raw", o_raw[0], 16'h1234);
        tick();
        check("abort_no_late_valid", o_valid[0], 0);

        // Reset in the middle of a draw.
        seed_with(16'h0003);
        rq = 1'b1;
        tick();
        rq = 1'b0;
        check("rst_mid_busy_before", o_busy[0], 1);
        do_reset();
        tick();
        check("rst_mid_no_valid", o_valid[0], 0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            sl = ($urandom_range(0, 49) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            fr = 1'($urandom);
            rq = 1'($urandom);
            tick();
        end

        // Back-to-back requests and output distribution.
        sl = 1'b0; fr = 1'b0; rq = 1'b0;
        seed_with(16'hACE1);
        rq = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (o_valid[0]) begin
                cnt[o_value[0]]++;
                total++;
            end
        end
        rq = 1'b0;
        tick();
        check("dist_total_min", 32'(total >= 300), 1);
        check("dist_out_of_range", cnt[3], 0);
        for (int v = 0; v < 3; v++)
            check($sformatf("dist_pct_%0d", v),
                  32'((cnt[v] * 100 >= total * 25) && (cnt[v] * 100 <= total * 42)), 1);
        check("pow2_fallback_count", fb2_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
